// File: rtl/iomem_pkg.sv
// ----------------------------------------------------------------------------
// iomem_pkg
// Shared types for the iomem bus-master engine: bus widths, the initiator FSM
// state encoding and the packed command record carried through the command
// FIFO. Imported by iomem_cmd_fifo and iomem_initiator.
// ----------------------------------------------------------------------------
package iomem_pkg;

    localparam int IOMEM_AW = 32;
    localparam int IOMEM_DW = 32;
    localparam int IOMEM_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } iomem_state_e;

    // 68-bit command record; wstrb == 0 marks a read.
    typedef struct packed {
        logic [IOMEM_AW-1:0] addr;
        logic [IOMEM_DW-1:0] wdata;
        logic [IOMEM_SW-1:0] wstrb;
    } iomem_cmd_t;

endpackage

// File: rtl/iomem_cmd_fifo.sv
// ----------------------------------------------------------------------------
// iomem_cmd_fifo
// Synchronous FIFO of iomem_cmd_t entries, FIFO_DEPTH deep (power of two).
// The head entry comes straight out of the register array, so it carries no
// combinational path from the push side.
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   push, push_data write one entry (ignored while full)
//   pop             retire the head entry (ignored while empty)
//   head            current head entry, meaningful while !empty
//   full, empty     occupancy flags, derived from registered pointers only
// ----------------------------------------------------------------------------
module iomem_cmd_fifo
    import iomem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  iomem_cmd_t push_data,
    input  logic       pop,
    output iomem_cmd_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    iomem_cmd_t  mem_q [FIFO_DEPTH];
    iomem_cmd_t  mem_d [FIFO_DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/iomem_initiator.sv
// ----------------------------------------------------------------------------
// iomem_initiator
// Bus-master engine for the PicoSoC iomem valid/ready bus. Commands are
// buffered in iomem_cmd_fifo, issued one at a time as an iomem transaction,
// and answered on a valid/ready response port.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (ready = FIFO not full)
//   cmd_addr/cmd_wdata/cmd_wstrb        command payload, wstrb 0 = read
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata/rsp_err                   read data (0 for writes/errors), timeout flag
//   iomem_valid/ready/wstrb/addr/wdata/rdata   iomem initiator side
//   busy                                FSM not idle or commands queued
//
// Build option: define IOMEM_INITIATOR_TIMEOUT_EN to abort a bus request that
// sees no iomem_ready for TIMEOUT_CYCLES cycles (rsp_err=1). Without it the
// bus waits indefinitely and rsp_err is constant 0.
// ----------------------------------------------------------------------------
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iomem_initiator: FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("iomem_initiator: TIMEOUT_CYCLES must be in 1..65535");
    end

    iomem_state_e state_q, state_d;
    logic         iomem_valid_q, iomem_valid_d;
    logic [31:0]  iomem_addr_q, iomem_addr_d;
    logic [31:0]  iomem_wdata_q, iomem_wdata_d;
    logic [3:0]   iomem_wstrb_q, iomem_wstrb_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_rdata_q, rsp_rdata_d;
    // Holds cmd_ready low through reset and lets it rise on the first edge after.
    logic         rdy_en_q;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    iomem_cmd_t   fifo_in, fifo_head;

    assign cmd_ready = rdy_en_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_in   = '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};

    iomem_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic        tmo_hit;
    // The counter holds the stall cycles already completed; +1 includes the
    // current cycle, so the abort lands at the end of the TIMEOUT_CYCLES-th
    // BUS cycle and a ready in that same cycle still wins.
    assign tmo_hit = (({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        iomem_valid_d = iomem_valid_q;
        iomem_addr_d  = iomem_addr_q;
        iomem_wdata_d = iomem_wdata_q;
        iomem_wstrb_d = iomem_wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        fifo_pop      = 1'b0;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    iomem_addr_d  = fifo_head.addr;
                    iomem_wdata_d = fifo_head.wdata;
                    iomem_wstrb_d = fifo_head.wstrb;
                    iomem_valid_d = 1'b1;
                    state_d       = ST_BUS;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
                    tmo_cnt_d     = '0;
`endif
                end
            end
            ST_BUS: begin
                if (iomem_ready) begin
                    iomem_valid_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (iomem_wstrb_q == 4'b0000) ? iomem_rdata : 32'h0;
                    state_d       = ST_RESP;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
                    rsp_err_d     = 1'b0;
                end else if (tmo_hit) begin
                    iomem_valid_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    tmo_cnt_d     = tmo_cnt_q + 16'd1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            iomem_valid_q <= 1'b0;
            iomem_addr_q  <= '0;
            iomem_wdata_q <= '0;
            iomem_wstrb_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rdy_en_q      <= 1'b0;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            iomem_valid_q <= iomem_valid_d;
            iomem_addr_q  <= iomem_addr_d;
            iomem_wdata_q <= iomem_wdata_d;
            iomem_wstrb_q <= iomem_wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rdy_en_q      <= 1'b1;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    assign iomem_valid = iomem_valid_q;
    assign iomem_addr  = iomem_addr_q;
    assign iomem_wdata = iomem_wdata_q;
    assign iomem_wstrb = iomem_wstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
